// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: decode/execute/memory/writeback operands in, stall/flush/forward controls out.
// Latency: pure wiring, no storage.
// Backpressure: none of its own; the hazard unit's stall outputs are the pipeline's backpressure.
interface hazard_unit_if;
    // decode stage
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       branchD;
    logic       jrD;
    logic       jalrD;
    // execute stage
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic [4:0] writeregE;
    logic       regwriteE;
    logic       memtoregE;
    logic       div_startE;
    logic       div_readyE;
    // memory / writeback stages
    logic [4:0] writeregM;
    logic       regwriteM;
    logic       memtoregM;
    logic [4:0] writeregW;
    logic       regwriteW;
    logic       exceptM;
    // controls back to the pipeline
    logic       forwardAD;
    logic       forwardBD;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       flushW;
    logic       div_cancel;
    logic       div_busy;
    logic [5:0] div_cycles;

    // pipeline side
    modport master (
        output rsD, rtD, branchD, jrD, jalrD,
        output rsE, rtE, writeregE, regwriteE, memtoregE, div_startE, div_readyE,
        output writeregM, regwriteM, memtoregM, writeregW, regwriteW, exceptM,
        input  forwardAD, forwardBD, forwardAE, forwardBE,
        input  stallF, stallD, stallE, flushD, flushE, flushM, flushW,
        input  div_cancel, div_busy, div_cycles
    );

    // hazard unit side
    modport slave (
        input  rsD, rtD, branchD, jrD, jalrD,
        input  rsE, rtE, writeregE, regwriteE, memtoregE, div_startE, div_readyE,
        input  writeregM, regwriteM, memtoregM, writeregW, regwriteW, exceptM,
        output forwardAD, forwardBD, forwardAE, forwardBE,
        output stallF, stallD, stallE, flushD, flushE, flushM, flushW,
        output div_cancel, div_busy, div_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stalls, multi-cycle divider tracking, exception flushes.
// Latency: forward/stall/flush/cancel are combinational; div_busy/div_cycles are registered state.
// Backpressure: divide holds F/D/E until div_readyE (released the same cycle); exceptM overrides all stalls.
module hazard_unit (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_t;

    div_state_t state;
    div_state_t state_nxt;
    logic [5:0] cycle_cnt;
    logic       lwstall;
    logic       brstall;
    logic       divstall;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // Operand forwarding into E (M beats W, it is the younger result) and into D compares.
    always_comb begin
        hz.forwardAE = 2'b00;
        hz.forwardBE = 2'b00;
        if (hz.regwriteM && reg_hit(hz.writeregM, hz.rsE)) begin
            hz.forwardAE = 2'b10;
        end else if (hz.regwriteW && reg_hit(hz.writeregW, hz.rsE)) begin
            hz.forwardAE = 2'b01;
        end
        if (hz.regwriteM && reg_hit(hz.writeregM, hz.rtE)) begin
            hz.forwardBE = 2'b10;
        end else if (hz.regwriteW && reg_hit(hz.writeregW, hz.rtE)) begin
            hz.forwardBE = 2'b01;
        end
        hz.forwardAD = hz.regwriteM && reg_hit(hz.writeregM, hz.rsD);
        hz.forwardBD = hz.regwriteM && reg_hit(hz.writeregM, hz.rtD);
    end

    // Data hazards that no forwarding path can cover.
    always_comb begin
        lwstall = hz.memtoregE && hz.regwriteE &&
                  (reg_hit(hz.writeregE, hz.rsD) || reg_hit(hz.writeregE, hz.rtD));
        brstall = (hz.branchD || hz.jrD || hz.jalrD) &&
                  ((hz.regwriteE && (reg_hit(hz.writeregE, hz.rsD) || reg_hit(hz.writeregE, hz.rtD))) ||
                   (hz.memtoregM && (reg_hit(hz.writeregM, hz.rsD) || reg_hit(hz.writeregM, hz.rtD))));
    end

    // Divider state register; reset abandons any divide in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Divider next state: an exception kills the divide even if its result arrives that cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hz.div_startE && !hz.exceptM) state_nxt = BUSY;
            BUSY: if (hz.div_readyE || hz.exceptM)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divider outputs and the stall/flush network built on top of them.
    always_comb begin
        divstall = ((state == IDLE) && hz.div_startE && !hz.exceptM) ||
                   ((state == BUSY) && !hz.div_readyE && !hz.exceptM);
        hz.div_cancel = (state == BUSY) && hz.exceptM;
        hz.div_busy   = (state == BUSY);
        hz.stallF     = (lwstall || brstall || divstall) && !hz.exceptM;
        hz.stallD     = (lwstall || brstall || divstall) && !hz.exceptM;
        hz.stallE     = divstall;
        // a held E stage must keep its instruction, so no bubble while the divider stalls it
        hz.flushE     = hz.exceptM || ((lwstall || brstall) && !divstall);
        hz.flushD     = hz.exceptM;
        hz.flushM     = hz.exceptM;
        hz.flushW     = hz.exceptM;
        hz.div_cycles = cycle_cnt;
    end

    // Busy-cycle counter: restarts with each divide, saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= 6'd0;
        end else if ((state == IDLE) && (state_nxt == BUSY)) begin
            cycle_cnt <= 6'd0;
        end else if ((state == BUSY) && (cycle_cnt != 6'd63)) begin
            cycle_cnt <= cycle_cnt + 6'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: vectors push expected controls, mid-cycle samples pop and compare.
// Latency: one vector per clock, sampled on the falling edge.
// Backpressure: none; watchdog bounds the run.
module tb_hazard_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_unit_if hif ();

    hazard_unit u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    // packed control word layout
    localparam logic [14:0] FAE_M = 15'd1 << 14;
    localparam logic [14:0] FAE_W = 15'd1 << 13;
    localparam logic [14:0] FBE_M = 15'd1 << 12;
    localparam logic [14:0] FBE_W = 15'd1 << 11;
    localparam logic [14:0] FAD   = 15'd1 << 10;
    localparam logic [14:0] FBD   = 15'd1 << 9;
    localparam logic [14:0] SF    = 15'd1 << 8;
    localparam logic [14:0] SD    = 15'd1 << 7;
    localparam logic [14:0] SE    = 15'd1 << 6;
    localparam logic [14:0] FD    = 15'd1 << 5;
    localparam logic [14:0] FE    = 15'd1 << 4;
    localparam logic [14:0] FM    = 15'd1 << 3;
    localparam logic [14:0] FW    = 15'd1 << 2;
    localparam logic [14:0] CAN   = 15'd1 << 1;
    localparam logic [14:0] BSY   = 15'd1;
    localparam logic [14:0] STL   = SF | SD;
    localparam logic [14:0] EXC   = FD | FE | FM | FW;
    localparam logic [14:0] NONE  = 15'd0;

    typedef struct {
        string       tag;
        logic [14:0] ctl;
        int          cyc;   // -1: div_cycles not checked
    } sb_entry_t;

    sb_entry_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] ctl_now();
        return {hif.forwardAE, hif.forwardBE, hif.forwardAD, hif.forwardBD,
                hif.stallF, hif.stallD, hif.stallE,
                hif.flushD, hif.flushE, hif.flushM, hif.flushW,
                hif.div_cancel, hif.div_busy};
    endfunction

    task automatic sb_push(input string tag, input logic [14:0] ctl, input int cyc);
        sb_entry_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check();
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_ctl"}, {17'd0, ctl_now()}, {17'd0, e.ctl});
            if (e.cyc >= 0) chk({e.tag, "_cyc"}, {26'd0, hif.div_cycles}, e.cyc);
        end
    endtask

    // one clocked vector: expectation queued now, compared on the falling edge
    task automatic vec(input string tag, input logic [14:0] ctl, input int cyc);
        sb_push(tag, ctl, cyc);
        @(negedge clk);
        sb_pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.rsD = 5'd0;  hif.rtD = 5'd0;
        hif.branchD = 1'b0; hif.jrD = 1'b0; hif.jalrD = 1'b0;
        hif.rsE = 5'd0;  hif.rtE = 5'd0; hif.writeregE = 5'd0;
        hif.regwriteE = 1'b0; hif.memtoregE = 1'b0;
        hif.div_startE = 1'b0; hif.div_readyE = 1'b0;
        hif.writeregM = 5'd0; hif.regwriteM = 1'b0; hif.memtoregM = 1'b0;
        hif.writeregW = 5'd0; hif.regwriteW = 1'b0; hif.exceptM = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();

        // reset state
        vec("reset", NONE, 0);
        rst = 1'b1;

        // load-use
        hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd5; hif.rsD = 5'd5;
        vec("lw_rs", STL | FE, -1);
        hif.writeregE = 5'd0; hif.rsD = 5'd0;
        vec("lw_r0", NONE, -1);
        hif.writeregE = 5'd12; hif.rtD = 5'd12; hif.rsD = 5'd3;
        vec("lw_rt", STL | FE, -1);
        clear_inputs();

        // E-stage forwarding
        hif.regwriteM = 1'b1; hif.regwriteW = 1'b1;
        hif.writeregM = 5'd7; hif.writeregW = 5'd7; hif.rsE = 5'd7;
        vec("fwd_prio", FAE_M, -1);
        hif.rsE = 5'd0;
        vec("fwd_r0", NONE, -1);
        hif.writeregM = 5'd4; hif.writeregW = 5'd9; hif.rsE = 5'd4; hif.rtE = 5'd9;
        vec("fwd_mw", FAE_M | FBE_W, -1);
        hif.regwriteM = 1'b0;
        vec("fwd_nowm", FBE_W, -1);
        hif.writeregM = 5'd9; hif.regwriteM = 1'b1; hif.rtE = 5'd9; hif.rsE = 5'd9;
        vec("fwd_both_m", FAE_M | FBE_M, -1);
        clear_inputs();

        // branch hazard, then producer moves to M
        hif.branchD = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd3; hif.rtD = 5'd3;
        vec("br_e", STL | FE, -1);
        hif.regwriteE = 1'b0; hif.writeregE = 5'd0;
        hif.regwriteM = 1'b1; hif.writeregM = 5'd3; hif.memtoregM = 1'b0;
        vec("br_m_fwd", FBD, -1);
        hif.memtoregM = 1'b1;
        vec("br_m_load", FBD | STL | FE, -1);
        hif.branchD = 1'b0;
        vec("nobr_m_load", FBD, -1);
        hif.rsD = 5'd3; hif.rtD = 5'd0;
        vec("fwd_ad", FAD, -1);
        clear_inputs();
        hif.jrD = 1'b1; hif.rsD = 5'd6; hif.regwriteE = 1'b1; hif.writeregE = 5'd6;
        vec("jr_e", STL | FE, -1);
        clear_inputs();
        hif.jalrD = 1'b1; hif.rtD = 5'd8; hif.regwriteE = 1'b1; hif.writeregE = 5'd8;
        vec("jalr_e", STL | FE, -1);
        clear_inputs();

        // exception with a divide request in IDLE: no divide starts
        hif.div_startE = 1'b1; hif.exceptM = 1'b1;
        vec("exc_idle", EXC, -1);
        clear_inputs();
        vec("exc_idle_after", NONE, 0);

        // 32-cycle divide, with a load-use hazard while E is held
        hif.div_startE = 1'b1;
        vec("div_go", STL | SE, 0);
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin
                hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd5; hif.rsD = 5'd5;
            end
            vec($sformatf("div_busy%0d", i), STL | SE | BSY, i);
            hif.memtoregE = 1'b0; hif.regwriteE = 1'b0; hif.writeregE = 5'd0; hif.rsD = 5'd0;
        end
        hif.div_readyE = 1'b1;
        vec("div_ready", BSY, 32);
        clear_inputs();
        vec("div_idle", NONE, -1);

        // long divide: counter saturates, then exception aborts
        hif.div_startE = 1'b1;
        vec("sat_go", STL | SE, -1);
        for (int i = 0; i < 70; i++) begin
            vec($sformatf("sat_busy%0d", i), STL | SE | BSY, (i > 63) ? 63 : i);
        end
        hif.exceptM = 1'b1;
        vec("abort", EXC | CAN | BSY, 63);
        clear_inputs();
        vec("abort_after", NONE, -1);

        // exception and result in the same cycle: exception wins
        hif.div_startE = 1'b1;
        vec("race_go", STL | SE, -1);
        for (int i = 0; i < 3; i++) begin
            vec($sformatf("race_busy%0d", i), STL | SE | BSY, i);
        end
        hif.div_readyE = 1'b1; hif.exceptM = 1'b1;
        vec("race", EXC | CAN | BSY, 3);
        clear_inputs();
        vec("race_after", NONE, -1);

        // asynchronous reset mid-divide
        hif.div_startE = 1'b1;
        vec("ar_go", STL | SE, -1);
        for (int i = 0; i < 10; i++) begin
            vec($sformatf("ar_busy%0d", i), STL | SE | BSY, i);
        end
        hif.div_startE = 1'b0;
        rst = 1'b0;
        #1;
        sb_push("ar_async", NONE, 0);
        sb_pop_check();
        vec("ar_held", NONE, 0);
        rst = 1'b1;
        vec("ar_release", NONE, 0);
        vec("ar_no_resume", NONE, 0);
        hif.div_startE = 1'b1;
        vec("ar_restart", STL | SE, 0);
        vec("ar_restart_busy", STL | SE | BSY, 0);
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports: clk in 1, pipeline clock (rising edge); rst in 1, asynchronous active-low reset.
REQ-002 SHALL take decode inputs: rsD in 5, rtD in 5, branchD in 1, jrD in 1, jalrD in 1.
REQ-003 SHALL take execute inputs: rsE in 5, rtE in 5, writeregE in 5, regwriteE in 1, memtoregE in 1.
REQ-004 SHALL take divider inputs: div_startE in 1 (divide op in E), div_readyE in 1 (result valid).
REQ-005 SHALL take memory/writeback inputs: writeregM in 5, regwriteM in 1, memtoregM in 1, writeregW in 5, regwriteW in 1, exceptM in 1 (exception or eret taken in M).
REQ-006 SHALL drive: forwardAD out 1, forwardBD out 1 (M to D compare operands); forwardAE out 2, forwardBE out 2 (00 regfile, 01 W, 10 M).
REQ-007 SHALL drive: stallF, stallD, stallE out 1 each; flushD, flushE, flushM, flushW out 1 each; div_cancel out 1; div_busy out 1; div_cycles out 6 (busy-cycle count of the current divide).

Function
REQ-008 Register 0 SHALL never match any hazard or forwarding comparison.
REQ-009 forwardAE SHALL be 10 if regwriteM and writeregM==rsE, else 01 if regwriteW and writeregW==rsE, else 00; M has priority over W; forwardBE is the same using rtE.
REQ-010 forwardAD SHALL be 1 iff regwriteM and writeregM==rsD; forwardBD is the same using rtD.
REQ-011 lwstall SHALL be memtoregE and regwriteE and writeregE equal to rsD or rtD.
REQ-012 brstall SHALL be (branchD or jrD or jalrD) and either (regwriteE and writeregE equal to rsD or rtD) or (memtoregM and writeregM equal to rsD or rtD).
REQ-013 A divider FSM with states IDLE and BUSY SHALL be held in a state register.
REQ-014 FSM transitions: IDLE to BUSY when div_startE and not exceptM; BUSY to IDLE when div_readyE or exceptM; all other cases hold.
REQ-015 divstall SHALL be (IDLE and div_startE and not exceptM) or (BUSY and not div_readyE and not exceptM).
REQ-016 div_busy SHALL be 1 iff the state is BUSY.
REQ-017 div_cycles SHALL clear to 0 on the IDLE-to-BUSY transition, increment by 1 each BUSY cycle, and saturate at 63 without wrapping.
REQ-018 div_cancel SHALL be a one-cycle combinational pulse equal to BUSY and exceptM.
REQ-019 stallF and stallD SHALL be (lwstall or brstall or divstall) and not exceptM.
REQ-020 stallE SHALL be divstall.
REQ-021 flushE SHALL be exceptM, or ((lwstall or brstall) and not divstall); a stalled E stage is never bubbled.
REQ-022 flushD, flushM and flushW SHALL equal exceptM.
REQ-023 When exceptM and div_readyE are asserted in the same cycle, exceptM SHALL win: FSM goes to IDLE, div_cancel=1, flushes asserted.
REQ-024 When div_readyE is asserted, all stalls SHALL release in that same cycle (zero added latency).
REQ-025 All outputs other than div_busy and div_cycles SHALL be combinational; no output SHALL contain a combinational path from a state bit to the FSM next-state input.

Reset
REQ-026 When rst=0, the FSM SHALL go to IDLE and div_cycles to 0 immediately, independent of clk.
REQ-027 During reset all stall, flush and div_cancel outputs SHALL be 0 when div_startE=0 and exceptM=0.
REQ-028 Deassertion of rst SHALL take effect at the next rising edge of clk, and a divide active before reset SHALL NOT resume.

Verification
REQ-029 Load-use: memtoregE=1, regwriteE=1, writeregE=5, rsD=5 -> stallF=stallD=1, flushE=1, stallE=0.
REQ-030 Forward priority: regwriteM=1 and regwriteW=1 with writeregM=writeregW=rsE=7 -> forwardAE=10; same with rsE=0 -> forwardAE=00.
REQ-031 Divide: div_startE=1 with div_readyE=1 after 32 cycles -> stallE=1 for 33 cycles, div_cycles=32 at release, state returns to IDLE.
REQ-032 Abort: exceptM=1 while BUSY -> div_cancel=1 for 1 cycle, flushD/E/M/W=1, stalls=0, IDLE the next cycle.
REQ-033 Branch hazard: branchD=1, regwriteE=1, writeregE=rtD=3 -> stallD=1, flushE=1; the next cycle with the producer in M (memtoregM=0) -> forwardBD=1, no stall.
REQ-034 Async reset mid-divide: rst=0 while BUSY with div_cycles=10 -> div_busy=0 and div_cycles=0 before the next clock edge.
